// File: rtl/five_point_eight_threading_adder.sv
// -----------------------------------------------------------------------------
// five_point_eight_threading_adder
//
// 4-bit carry-lookahead adder with a single registered output stage.
// Every carry is formed in parallel from the per-bit propagate/generate terms
// and Cin, so there is no ripple chain through the slice. The group
// propagate/generate terms are registered alongside the sum, so a parent can
// cascade several slices through a second-level lookahead unit.
//
// Ports
//   clk   in   1  system clock, rising edge
//   rst   in   1  synchronous reset, active-high
//   A     in   4  addend A, unsigned
//   B     in   4  addend B, unsigned
//   Cin   in   1  carry into bit 0
//   S     out  4  registered sum
//   Cout  out  1  registered carry out of bit 3
//   PG    out  1  registered group propagate
//   GG    out  1  registered group generate
// -----------------------------------------------------------------------------
module five_point_eight_threading_adder (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       Cin,
    output logic [3:0] S,
    output logic       Cout,
    output logic       PG,
    output logic       GG
);

    logic [3:0] p;
    logic [3:0] g;
    logic [4:0] c;
    logic [3:0] sum_d;
    logic       pg_d;
    logic       gg_d;

    always_comb begin
        p = A ^ B;
        g = A & B;

        // Each carry is a flat sum of products; no term depends on another carry.
        c[0] = Cin;
        c[1] = g[0]
             | (p[0] & Cin);
        c[2] = g[1]
             | (p[1] & g[0])
             | (p[1] & p[0] & Cin);
        c[3] = g[2]
             | (p[2] & g[1])
             | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & Cin);
        c[4] = g[3]
             | (p[3] & g[2])
             | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & Cin);

        pg_d  = p[3] & p[2] & p[1] & p[0];
        gg_d  = g[3]
              | (p[3] & g[2])
              | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]);

        sum_d = p ^ c[3:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            S    <= 4'b0000;
            Cout <= 1'b0;
            PG   <= 1'b0;
            GG   <= 1'b0;
        end else begin
            S    <= sum_d;
            Cout <= c[4];
            PG   <= pg_d;
            GG   <= gg_d;
        end
    end

endmodule

// File: tb/tb_five_point_eight_threading_adder.sv
// -----------------------------------------------------------------------------
// Bench for five_point_eight_threading_adder. Expected outputs come from an
// arithmetic model: the sum is A+B+Cin, the group generate is "A+B alone
// overflows 4 bits", the group propagate is "A+B alone equals 15".
// -----------------------------------------------------------------------------
module tb_five_point_eight_threading_adder;

    logic       clk;
    logic       rst;
    logic [3:0] A;
    logic [3:0] B;
    logic       Cin;
    logic [3:0] S;
    logic       Cout;
    logic       PG;
    logic       GG;

    int total = 0;
    int bad   = 0;

    five_point_eight_threading_adder dut (
        .clk  (clk),
        .rst  (rst),
        .A    (A),
        .B    (B),
        .Cin  (Cin),
        .S    (S),
        .Cout (Cout),
        .PG   (PG),
        .GG   (GG)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Returns {GG, PG, Cout, S[3:0]}.
    function automatic logic [6:0] model(input logic [3:0] a, input logic [3:0] b,
                                         input logic cin);
        int full;
        int ab;
        logic [6:0] r;
        ab   = int'(a) + int'(b);
        full = ab + int'(cin);
        r[3:0] = full[3:0];
        r[4]   = (full > 15);
        r[5]   = (ab == 15);
        r[6]   = (ab > 15);
        return r;
    endfunction

    task automatic test_reset();
        logic [6:0] obs;
        @(negedge clk);
        rst = 1'b1; A = 4'hF; B = 4'hF; Cin = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            obs = {GG, PG, Cout, S};
            total++;
            if (obs !== 7'b0) begin
                bad++;
                $display("FAIL reset_edge%0d: got %b want 0000000", i, obs);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        obs = {GG, PG, Cout, S};
        total++;
        if (obs !== 7'b1011111) begin
            bad++;
            $display("FAIL reset_release: got %b want 1011111", obs);
        end
    endtask

    task automatic test_directed();
        logic [3:0] va [6];
        logic [3:0] vb [6];
        logic       vc [6];
        logic [6:0] want [6];
        logic [6:0] obs;
        va[0] = 4'b0001; vb[0] = 4'b0010; vc[0] = 1'b0; want[0] = 7'b0000011;
        va[1] = 4'b0101; vb[1] = 4'b0011; vc[1] = 1'b1; want[1] = 7'b0001001;
        va[2] = 4'b1111; vb[2] = 4'b1111; vc[2] = 1'b1; want[2] = 7'b1011111;
        va[3] = 4'b1010; vb[3] = 4'b0101; vc[3] = 1'b0; want[3] = 7'b0101111;
        va[4] = 4'b1010; vb[4] = 4'b0101; vc[4] = 1'b1; want[4] = 7'b0110000;
        va[5] = 4'b0000; vb[5] = 4'b0000; vc[5] = 1'b0; want[5] = 7'b0000000;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            A = va[i]; B = vb[i]; Cin = vc[i];
            @(posedge clk); #1;
            obs = {GG, PG, Cout, S};
            total++;
            if (obs !== want[i]) begin
                bad++;
                $display("FAIL directed%0d A=%b B=%b Cin=%b: got %b want %b",
                         i, va[i], vb[i], vc[i], obs, want[i]);
            end
        end
    endtask

    // Inputs changing after the edge must not disturb the held result.
    task automatic test_hold();
        logic [6:0] want;
        logic [6:0] obs;
        @(negedge clk);
        A = 4'd9; B = 4'd8; Cin = 1'b0;
        want = model(4'd9, 4'd8, 1'b0);
        @(posedge clk); #1;
        A = 4'd1; B = 4'd1; Cin = 1'b1;
        #3;
        obs = {GG, PG, Cout, S};
        total++;
        if (obs !== want) begin
            bad++;
            $display("FAIL hold: got %b want %b", obs, want);
        end
    endtask

    // Each combination is presented for one cycle; the result launched at one
    // negedge is checked at the following negedge, which pins latency to 1.
    task automatic test_sweep();
        int         rst_idx;
        logic [6:0] exp_q;
        logic       have_exp;
        logic [6:0] obs;
        rst_idx  = int'($urandom_range(50, 450));
        have_exp = 1'b0;
        exp_q    = '0;
        for (int idx = 0; idx <= 512; idx++) begin
            @(negedge clk);
            if (have_exp) begin
                obs = {GG, PG, Cout, S};
                total++;
                if (obs !== exp_q) begin
                    bad++;
                    $display("FAIL sweep idx=%0d: got %b want %b", idx - 1, obs, exp_q);
                end
            end
            if (idx < 512) begin
                A   = idx[3:0];
                B   = idx[7:4];
                Cin = idx[8];
                rst = (idx == rst_idx);
                exp_q    = rst ? 7'b0 : model(idx[3:0], idx[7:4], idx[8]);
                have_exp = 1'b1;
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [3:0] a;
        logic [3:0] b;
        logic       ci;
        logic [6:0] exp_q;
        logic [6:0] obs;
        @(negedge clk);
        a = 4'($urandom); b = 4'($urandom); ci = 1'($urandom);
        A = a; B = b; Cin = ci;
        exp_q = model(a, b, ci);
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            obs = {GG, PG, Cout, S};
            total++;
            if (obs !== exp_q) begin
                bad++;
                $display("FAIL random%0d: got %b want %b", n, obs, exp_q);
            end
            a = 4'($urandom); b = 4'($urandom); ci = 1'($urandom);
            A = a; B = b; Cin = ci;
            exp_q = model(a, b, ci);
        end
    endtask

    initial begin
        rst = 1'b1;
        A   = 4'h0;
        B   = 4'h0;
        Cin = 1'b0;
        test_reset();
        test_directed();
        test_hold();
        test_sweep();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
